// File: rtl/ram_bw_sp_clr.sv
// Single-port synchronous SRAM with byte-lane writes, read-first behaviour, an optional output
// register and a zero-fill clear engine that sweeps the whole array after reset or on request.
module ram_bw_sp_clr #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 12,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            EN,
  input  logic [DW/8-1:0] WE,
  input  logic [AW-1:0]   A,
  input  logic [DW-1:0]   Di,
  output logic [DW-1:0]   Do,
  output logic            VLD,
  input  logic            CLR,
  output logic            RDY
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned Depth = 1 << AW;

  typedef enum logic {StReady, StClear} state_e;

  localparam state_e StReset  = (CLR_ON_RST != 0) ? StClear : StReady;
  localparam logic   RdyReset = (CLR_ON_RST == 0);

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            rdy_q;
  logic [DW-1:0]   mem [Depth];
  logic [DW-1:0]   s1_data_q;
  logic            s1_vld_q;
  logic            acc_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [NB-1:0]   mem_be;

  // A clear request in the same cycle as an access wins and drops the access.
  assign acc_en = (state_q == StReady) && EN && !CLR;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StReset;
      rdy_q   <= RdyReset;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StReady: begin
          if (CLR) begin
            state_q <= StClear;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          // Leave at the top address; the counter never wraps into a second pass.
          if (&cnt_q) begin
            state_q <= StReady;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = A;
    mem_wdata = Di;
    mem_be    = '0;
    if (state_q == StClear) begin
      mem_addr  = cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (acc_en) begin
      mem_be = WE;
    end
  end

  // Array has no reset: contents survive RESETn.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_be[i]) begin
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end else if (acc_en) begin
      s1_data_q <= mem[A];
      s1_vld_q  <= 1'b1;
    end else begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] s2_data_q;
    logic          s2_vld_q;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        s2_data_q <= '0;
        s2_vld_q  <= 1'b0;
      end else begin
        s2_data_q <= s1_data_q;
        s2_vld_q  <= s1_vld_q;
      end
    end

    assign Do  = s2_data_q;
    assign VLD = s2_vld_q;
  end else begin : g_no_out_reg
    assign Do  = s1_data_q;
    assign VLD = s1_vld_q;
  end

  assign RDY = rdy_q;

endmodule

// File: tb/tb_ram_bw_sp_clr.sv
// Directed bench: dut_a has latency 1 and clears on reset, dut_b has latency 2 and starts ready.
module tb_ram_bw_sp_clr;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        clr   = 1'b0;
  logic [3:0]  we    = '0;
  logic [3:0]  a     = '0;
  logic [31:0] di    = '0;
  logic [31:0] do_a, do_b;
  logic        vld_a, vld_b, rdy_a, rdy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bw_sp_clr #(.DW(32), .AW(4), .OUT_REG(0), .CLR_ON_RST(1)) dut_a (
    .CLK(clk), .RESETn(rst_n), .EN(en), .WE(we), .A(a), .Di(di),
    .Do(do_a), .VLD(vld_a), .CLR(clr), .RDY(rdy_a)
  );

  ram_bw_sp_clr #(.DW(32), .AW(4), .OUT_REG(1), .CLR_ON_RST(0)) dut_b (
    .CLK(clk), .RESETn(rst_n), .EN(en), .WE(we), .A(a), .Di(di),
    .Do(do_b), .VLD(vld_b), .CLR(clr), .RDY(rdy_b)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [3:0]  a;
    logic [31:0] di;
    logic [31:0] exp_do;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [3:0] ad,
                       input logic [31:0] d, input logic c);
    en  = e;
    we  = w;
    a   = ad;
    di  = d;
    clr = c;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 32'h00000000, 1'b1};
    vecs[1]  = '{1'b1, 4'h5, 4'd3,  32'h11223344, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b1, 4'h0, 4'd3,  32'h00000000, 32'hDE22BE44, 1'b1};
    vecs[3]  = '{1'b0, 4'h0, 4'd3,  32'h00000000, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 4'h3, 4'd7,  32'h1234CAFE, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 4'h0, 4'd7,  32'h00000000, 32'h0000CAFE, 1'b1};
    vecs[6]  = '{1'b1, 4'h8, 4'd7,  32'h99887766, 32'h0000CAFE, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 4'd7,  32'h00000000, 32'h9900CAFE, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 4'd3,  32'h00000000, 32'hDE22BE44, 1'b1};
    vecs[9]  = '{1'b1, 4'hF, 4'd15, 32'h12345678, 32'h00000000, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 4'd15, 32'h00000000, 32'h12345678, 1'b1};
    vecs[11] = '{1'b0, 4'h0, 4'd15, 32'h00000000, 32'h00000000, 1'b0};

    // Reset and the automatic sweep.
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    tick(); tick(); tick();
    check("rst_do_a", do_a, 32'h0);
    check1("rst_vld_a", vld_a, 1'b0);
    check1("rst_rdy_a", rdy_a, 1'b0);
    check1("rst_rdy_b", rdy_b, 1'b1);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check1($sformatf("sweep1_rdy_a_%0d", k), rdy_a, k == 16);
      if (k == 1) check1("noclr_rdy_b", rdy_b, 1'b1);
    end

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b0);
      tick();
      check($sformatf("zero_do_%0d", i), do_a, 32'h0);
      check1($sformatf("zero_vld_%0d", i), vld_a, 1'b1);
    end

    // Byte-lane writes and read-first, latency 1.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].di, 1'b0);
      tick();
      check($sformatf("vec%0d_do", i), do_a, vecs[i].exp_do);
      check1($sformatf("vec%0d_vld", i), vld_a, vecs[i].exp_vld);
    end

    // Latency-2 stream on dut_b.
    drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
    tick();
    check1("oreg_early_vld", vld_b, 1'b0);
    check("lat1_do_a", do_a, 32'hDE22BE44);
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
    tick();
    check("oreg_do_3", do_b, 32'hDE22BE44);
    check1("oreg_vld_3", vld_b, 1'b1);
    drive(1'b1, 4'h0, 4'd15, 32'h0, 1'b0);
    tick();
    check("oreg_do_7", do_b, 32'h9900CAFE);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    tick();
    check("oreg_do_15", do_b, 32'h12345678);
    check1("oreg_vld_15", vld_b, 1'b1);
    tick();
    check("oreg_idle_do", do_b, 32'h0);
    check1("oreg_idle_vld", vld_b, 1'b0);

    // Clear request with a colliding write; writes and a second CLR during the sweep are ignored.
    drive(1'b1, 4'hF, 4'd5, 32'hA5A5A5A5, 1'b1);
    tick();
    check1("clr_drop_vld_a", vld_a, 1'b0);
    check1("clr_rdy_a", rdy_a, 1'b0);
    check1("clr_rdy_b", rdy_b, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 4'hF, 4'd2, 32'hFFFFFFFF, k == 5);
      tick();
      check1($sformatf("sweep2_rdy_a_%0d", k), rdy_a, k == 16);
      check1($sformatf("sweep2_rdy_b_%0d", k), rdy_b, k == 16);
      check1($sformatf("sweep2_vld_a_%0d", k), vld_a, 1'b0);
      check1($sformatf("sweep2_vld_b_%0d", k), vld_b, 1'b0);
    end
    drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
    tick();
    check("clr_a5_do", do_a, 32'h0);
    check1("clr_a5_vld", vld_a, 1'b1);
    drive(1'b1, 4'h0, 4'd2, 32'h0, 1'b0);
    tick();
    check("clr_a2_do", do_a, 32'h0);
    check("clr_b5_do", do_b, 32'h0);
    check1("clr_b5_vld", vld_b, 1'b1);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    tick();
    check("clr_b2_do", do_b, 32'h0);

    // Reset in the middle of a sweep.
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    tick();
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    for (int k = 1; k <= 7; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_do_a", do_a, 32'h0);
    check1("midrst_vld_a", vld_a, 1'b0);
    check1("midrst_rdy_a", rdy_a, 1'b0);
    check1("midrst_rdy_b", rdy_b, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check1($sformatf("sweep3_rdy_a_%0d", k), rdy_a, k == 16);
      if (k == 1) check1("sweep3_rdy_b", rdy_b, 1'b1);
    end

    // Write then read next cycle, then async reset clears the output immediately.
    drive(1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0);
    tick();
    drive(1'b1, 4'h0, 4'd9, 32'h0, 1'b0);
    tick();
    check("raw_do_a", do_a, 32'hCAFEF00D);
    drive(1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_do_a", do_a, 32'h0);
    check1("arst_vld_a", vld_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
